// File: rtl/riscv_pkg.sv
// Shared encodings for the ID-stage control-transfer logic: funct3 codes,
// br_kind codes, comparison-unit selects and the resolve FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'd0,
        KIND_JAL    = 2'd1,
        KIND_JALR   = 2'd2,
        KIND_RSVD   = 2'd3
    } br_kind_t;

    // GE/GEU reuse the LT/LTU selects with the flag inverted, so 4 and 5
    // are defined for the comparison unit but never driven from here.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LTU = 3'd2,
        CMP_LT  = 3'd3,
        CMP_GEU = 3'd4,
        CMP_GE  = 3'd5
    } cmp_sel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    // funct3 values 010 and 011 have no branch meaning
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

    function automatic cmp_sel_t f3_to_sel(input logic [2:0] f3);
        cmp_sel_t sel;
        case (f3)
            F3_BNE:           sel = CMP_NE;
            F3_BLT, F3_BGE:   sel = CMP_LT;
            F3_BLTU, F3_BGEU: sel = CMP_LTU;
            default:          sel = CMP_EQ;
        endcase
        return sel;
    endfunction

    function automatic logic f3_inverts(input logic [2:0] f3);
        return (f3 == F3_BGE) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // count up, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/JAL/JALR resolver: stalls until operands are forwarded,
// steers the shared comparator, then emits a redirect or misalign pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a control-transfer instruction in ID
// S_EVAL  | instruction captured, waiting for operands, comparator steered
// S_REDIR | taken target registered, redirect/flush asserted this cycle
module branch_resolve_ctrl
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [1:0]       br_kind,
    input  logic [2:0]       br_funct3,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] br_imm,
    input  logic             rs1_ready,
    input  logic             rs2_ready,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic             cmp_flag,
    input  logic             kill,
    input  logic             cnt_clr,
    output logic [2:0]       cmp_sel,
    output logic             stall,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic             misalign,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t           state;
    br_kind_t         kind_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] imm_q;
    logic             misalign_q;
    logic             illegal_q;

    logic             legal;
    logic             ops_ready;
    logic             taken;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] target;
    logic             resolve;
    logic             br_inc;
    logic             tk_inc;

    assign legal = (br_kind != KIND_RSVD) &&
                   !((br_kind == KIND_BRANCH) && f3_illegal(br_funct3));

    // operand readiness, outcome and target of the captured instruction
    always_comb begin
        ops_ready = 1'b1;
        taken     = 1'b1;
        sum       = pc_q + imm_q;
        case (kind_q)
            KIND_BRANCH: begin
                ops_ready = rs1_ready && rs2_ready;
                taken     = cmp_flag ^ f3_inverts(funct3_q);
            end
            KIND_JALR: begin
                ops_ready = rs1_ready;
                sum       = rs1_data + imm_q;
            end
            default: ;
        endcase
        // JALR drops bit 0 of its target; branch/JAL offsets are even anyway
        target = {sum[WIDTH-1:1], sum[0] & (kind_q != KIND_JALR)};
    end

    assign resolve = (state == S_EVAL) && !kill && ops_ready;
    assign br_inc  = resolve && (kind_q == KIND_BRANCH);
    assign tk_inc  = br_inc && taken;

    // resolve FSM with registered capture, target and pulse flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            kind_q      <= KIND_BRANCH;
            funct3_q    <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            redirect_pc <= '0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (br_valid && !kill) begin
                        if (legal) begin
                            kind_q   <= br_kind_t'(br_kind);
                            funct3_q <= br_funct3;
                            pc_q     <= br_pc;
                            imm_q    <= br_imm;
                            state    <= S_EVAL;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    if (kill) begin
                        state <= S_IDLE;
                    end else if (ops_ready) begin
                        if (taken && target[1]) begin
                            misalign_q <= 1'b1;
                            state      <= S_IDLE;
                        end else if (taken) begin
                            redirect_pc <= target;
                            state       <= S_REDIR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_REDIR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmp_sel = ((state == S_EVAL) && (kind_q == KIND_BRANCH)) ?
                     f3_to_sel(funct3_q) : CMP_EQ;
    assign stall          = ((state == S_IDLE) && br_valid && legal) || (state == S_EVAL);
    assign redirect_valid = (state == S_REDIR) && !kill;
    assign flush          = redirect_valid;
    assign misalign       = misalign_q && !kill;
    assign illegal        = illegal_q;

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (br_inc),
        .clr   (cnt_clr),
        .count (branch_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (tk_inc),
        .clr   (cnt_clr),
        .count (taken_count)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: table of single instructions plus
// hand-written multi-cycle sequences; redirect/misalign/illegal events are
// matched against a queue of expected events by a monitor.
module tb_branch_resolve_ctrl;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid;
    logic [1:0]    br_kind;
    logic [2:0]    br_funct3;
    logic [W-1:0]  br_pc;
    logic [W-1:0]  br_imm;
    logic          rs1_ready;
    logic          rs2_ready;
    logic [W-1:0]  rs1_data;
    logic          cmp_flag;
    logic          kill;
    logic          cnt_clr;
    logic [2:0]    cmp_sel;
    logic          stall;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          flush;
    logic          misalign;
    logic          illegal;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] taken_count;

    branch_resolve_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_kind        (br_kind),
        .br_funct3      (br_funct3),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .rs1_ready      (rs1_ready),
        .rs2_ready      (rs2_ready),
        .rs1_data       (rs1_data),
        .cmp_flag       (cmp_flag),
        .kill           (kill),
        .cnt_clr        (cnt_clr),
        .cmp_sel        (cmp_sel),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .misalign       (misalign),
        .illegal        (illegal),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // event kinds: 1 redirect, 2 misalign, 3 illegal
    typedef struct {
        int          evt;
        logic [31:0] pc;
    } ev_t;
    ev_t sbq[$];

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        flag;
        logic        legal;
        logic [2:0]  sel;
        int          evt;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    ev_t exp_ev;
    int  act_evt;

    // scoreboard monitor: every output pulse must match the next expected event
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (flush !== redirect_valid) begin
                errors++;
                $display("FAIL flush_eq_redirect: flush=%0b redirect_valid=%0b at %0t",
                         flush, redirect_valid, $time);
            end
            if (redirect_valid || misalign || illegal) begin
                act_evt = redirect_valid ? 1 : (misalign ? 2 : 3);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got kind %0d expected none at %0t", act_evt, $time);
                end else begin
                    exp_ev = sbq.pop_front();
                    check("sb_event_kind", act_evt, exp_ev.evt);
                    if (act_evt == 1) check("sb_redirect_pc", redirect_pc, exp_ev.pc);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic flag);
        br_valid  = 1'b1;
        br_kind   = kind;
        br_funct3 = f3;
        br_pc     = pc;
        br_imm    = imm;
        rs1_data  = rs1;
        cmp_flag  = flag;
    endtask

    // issue one instruction with operands ready, check cycles 0..2, drain to IDLE
    task automatic issue(input vec_t v);
        rs1_ready = 1'b1;
        rs2_ready = 1'b1;
        drive(v.kind, v.f3, v.pc, v.imm, v.rs1, v.flag);
        if (v.evt != 0) sbq.push_back('{v.evt, v.exp_pc});
        @(negedge clk);
        check("c0_stall", stall, v.legal);
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        if (v.legal) begin
            check("c1_stall", stall, 1);
            check("c1_cmp_sel", cmp_sel, v.sel);
        end else begin
            check("c1_illegal", illegal, 1);
        end
        next_cycle();
        @(negedge clk);
        check("c2_redirect", redirect_valid, v.evt == 1);
        check("c2_misalign", misalign, v.evt == 2);
        check("c2_stall", stall, 0);
        next_cycle();
        next_cycle();
    endtask

    int stall_cnt;
    int seen;

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_kind = 2'd0; br_funct3 = 3'd0;
        br_pc = '0; br_imm = '0; rs1_ready = 1'b1; rs2_ready = 1'b1;
        rs1_data = '0; cmp_flag = 1'b0; kill = 1'b0; cnt_clr = 1'b0;

        // kind, f3, pc, imm, rs1, flag, legal, sel, evt, exp_pc
        vecs.push_back('{2'd0, 3'b000, 32'h100,      32'h40,       32'h0,    1'b1, 1'b1, 3'd0, 1, 32'h140});
        vecs.push_back('{2'd0, 3'b111, 32'h100,      32'h40,       32'h0,    1'b1, 1'b1, 3'd2, 0, 32'h0});
        vecs.push_back('{2'd0, 3'b001, 32'h200,      32'h10,       32'h0,    1'b1, 1'b1, 3'd1, 1, 32'h210});
        vecs.push_back('{2'd0, 3'b100, 32'h200,      32'h10,       32'h0,    1'b0, 1'b1, 3'd3, 0, 32'h0});
        vecs.push_back('{2'd0, 3'b101, 32'h300,      32'hFFFFFFF8, 32'h0,    1'b0, 1'b1, 3'd3, 1, 32'h2F8});
        vecs.push_back('{2'd0, 3'b110, 32'h400,      32'h20,       32'h0,    1'b1, 1'b1, 3'd2, 1, 32'h420});
        vecs.push_back('{2'd1, 3'b000, 32'hFFFFFFFC, 32'h8,        32'h0,    1'b0, 1'b1, 3'd0, 1, 32'h4});
        vecs.push_back('{2'd1, 3'b000, 32'h100,      32'h6,        32'h0,    1'b0, 1'b1, 3'd0, 2, 32'h0});
        vecs.push_back('{2'd2, 3'b000, 32'h600,      32'h1,        32'h3003, 1'b0, 1'b1, 3'd0, 1, 32'h3004});
        vecs.push_back('{2'd2, 3'b000, 32'h600,      32'h2,        32'h1000, 1'b0, 1'b1, 3'd0, 2, 32'h0});
        vecs.push_back('{2'd0, 3'b010, 32'h700,      32'h10,       32'h0,    1'b1, 1'b0, 3'd0, 3, 32'h0});
        vecs.push_back('{2'd3, 3'b000, 32'h700,      32'h10,       32'h0,    1'b1, 1'b0, 3'd0, 3, 32'h0});
        vecs.push_back('{2'd0, 3'b000, 32'h500,      32'h6,        32'h0,    1'b1, 1'b1, 3'd0, 2, 32'h0});

        // reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_cmp_sel", cmp_sel, 0);
        check("rst_stall", stall, 0);
        check("rst_redirect", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_flush", flush, 0);
        check("rst_misalign", misalign, 0);
        check("rst_illegal", illegal, 0);
        check("rst_branch_count", branch_count, 0);
        check("rst_taken_count", taken_count, 0);
        br_valid = 1'b1;
        #1;
        check("rst_stall_br_valid", stall, 1);
        br_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) issue(vecs[i]);
        check("table_branch_count", branch_count, 7);
        check("table_taken_count", taken_count, 5);

        // not-taken followed by capture in the IDLE cycle right after
        drive(2'd0, 3'b100, 32'h800, 32'h40, 32'h0, 1'b0);
        next_cycle();
        br_valid = 1'b0;
        @(negedge clk);
        check("b2b_cmp_sel", cmp_sel, 3);
        next_cycle();
        drive(2'd1, 3'b000, 32'h800, 32'h10, 32'h0, 1'b0);
        sbq.push_back('{1, 32'h810});
        @(negedge clk);
        check("b2b_capture_stall", stall, 1);
        next_cycle();
        br_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check("b2b_redirect", redirect_valid, 1);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("redirect_pc_hold", redirect_pc, 32'h810);
        check("b2b_branch_count", branch_count, 8);
        next_cycle();

        // JALR with rs1 late for three EVAL cycles
        sbq.push_back('{1, 32'h2004});
        stall_cnt = 0;
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) drive(2'd2, 3'b000, 32'h900, 32'h4, 32'h2001, 1'b0);
            else br_valid = 1'b0;
            rs1_ready = (i >= 4);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (redirect_valid) begin
                seen = i;
                break;
            end
            next_cycle();
        end
        check("jalr_redirect_cycle", seen, 5);
        check("jalr_stall_cycles", stall_cnt, 5);
        rs1_ready = 1'b1;
        next_cycle();
        next_cycle();

        // kill in EVAL: no redirect, no counter change
        drive(2'd0, 3'b000, 32'hA00, 32'h40, 32'h0, 1'b1);
        next_cycle();
        br_valid = 1'b0;
        kill = 1'b1;
        next_cycle();
        kill = 1'b0;
        @(negedge clk);
        check("kill_eval_redirect", redirect_valid, 0);
        check("kill_eval_stall", stall, 0);
        check("kill_eval_branch_count", branch_count, 8);
        check("kill_eval_taken_count", taken_count, 5);
        next_cycle();

        // kill in IDLE blocks capture
        drive(2'd0, 3'b000, 32'hA00, 32'h40, 32'h0, 1'b1);
        kill = 1'b1;
        next_cycle();
        br_valid = 1'b0;
        kill = 1'b0;
        @(negedge clk);
        check("kill_idle_no_eval", stall, 0);
        next_cycle();
        next_cycle();

        // kill in REDIR suppresses the redirect pulse itself
        drive(2'd0, 3'b000, 32'hB00, 32'h40, 32'h0, 1'b1);
        next_cycle();
        br_valid = 1'b0;
        next_cycle();
        kill = 1'b1;
        @(negedge clk);
        check("kill_redir_redirect", redirect_valid, 0);
        check("kill_redir_flush", flush, 0);
        next_cycle();
        kill = 1'b0;
        next_cycle();

        // saturation: enough taken branches to pass all-ones
        for (int n = 0; n < 18; n++)
            issue('{2'd0, 3'b000, 32'h100, 32'h40, 32'h0, 1'b1, 1'b1, 3'd0, 1, 32'h140});
        check("sat_branch_count", branch_count, 4'hF);
        check("sat_taken_count", taken_count, 4'hF);

        // clear together with an increment
        drive(2'd0, 3'b000, 32'h100, 32'h40, 32'h0, 1'b1);
        sbq.push_back('{1, 32'h140});
        next_cycle();
        br_valid = 1'b0;
        cnt_clr = 1'b1;
        next_cycle();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr_branch_count", branch_count, 0);
        check("clr_taken_count", taken_count, 0);
        next_cycle();
        next_cycle();

        // reset in the middle of an EVAL
        drive(2'd0, 3'b000, 32'hC00, 32'h40, 32'h0, 1'b1);
        next_cycle();
        br_valid = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        check("midrst_redirect", redirect_valid, 0);
        check("midrst_stall", stall, 0);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("midrst_after_redirect", redirect_valid, 0);
        check("midrst_branch_count", branch_count, 0);
        next_cycle();
        next_cycle();

        check("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
